// File: rtl/glitch_filter_mc.sv
// Multi-channel glitch filter / debouncer: per-channel synchroniser plus a
// run-length (consecutive) or up/down (integrating) qualification counter.
module glitch_filter_mc #(
    parameter int   CHANNELS    = 8,
    parameter int   CNT_W       = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    input  logic [CNT_W-1:0]    filt_len,
    input  logic                mode,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    logic [CHANNELS-1:0] s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
            logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_d;

            always_comb begin
                sync_d[0] = in;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= {CHANNELS{RESET_VAL}};
                    end
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [CHANNELS-1:0]            out_q, out_d;
    logic [CHANNELS-1:0]            rise_q, rise_d;
    logic [CHANNELS-1:0]            fall_q, fall_d;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                           mode_q, mode_d;
    logic [CNT_W-1:0]               len_eff;
    logic [CNT_W:0]                 thr;
    logic                           mode_chg;

    always_comb begin
        out_d    = out_q;
        rise_d   = '0;
        fall_d   = '0;
        cnt_d    = cnt_q;
        mode_d   = mode;
        len_eff  = (filt_len == '0) ? CNT_W'(1) : filt_len;
        thr      = {1'b0, len_eff};
        mode_chg = (mode != mode_q);

        for (int i = 0; i < CHANNELS; i++) begin
            // A mode switch freezes every channel for one cycle and drops progress.
            if (mode_chg) begin
                cnt_d[i] = '0;
            end else if (s[i] != out_q[i]) begin
                if (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= thr) begin
                    out_d[i]  = s[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (mode_q && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= {CHANNELS{RESET_VAL}};
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
            mode_q <= mode;
        end else begin
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign out     = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = |(rise_q | fall_q);

endmodule

// File: tb/tb_glitch_filter_mc.sv
// Directed bench for glitch_filter_mc: reset/latency table plus hand-written
// glitch, integration, threshold-change and mid-count disturbance sequences.
module tb_glitch_filter_mc;
  localparam int CH = 4;
  localparam int CW = 4;
  localparam int SS = 2;
  localparam int EW = 3 * CH + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] din;
  logic [CW-1:0] filt_len;
  logic          mode;
  logic [CH-1:0] out, rise, fall;
  logic          changed;

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic          rst_n;
    logic [CH-1:0] din;
    logic [CW-1:0] len;
    logic          mode;
    logic [CH-1:0] e_out;
    logic [CH-1:0] e_rise;
    logic [CH-1:0] e_fall;
    logic          e_chg;
  } vec_t;

  vec_t tbl[12];
  int pat[14] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};

  glitch_filter_mc #(
    .CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS), .RESET_VAL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .filt_len(filt_len), .mode(mode),
    .out(out), .rise(rise), .fall(fall), .changed(changed)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst_n = 1'b0;
    din   = '0;
    mode  = m;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string name, input int ch, input logic [15:0] exp);
    chk(name, 16'(dut.cnt_q[ch]), exp);
  endtask

  task automatic run_table();
    logic [EW-1:0] e;
    for (int r = 0; r < 12; r++) begin
      rst_n    = tbl[r].rst_n;
      din      = tbl[r].din;
      filt_len = tbl[r].len;
      mode     = tbl[r].mode;
      exp_q.push_back({tbl[r].e_out, tbl[r].e_rise, tbl[r].e_fall, tbl[r].e_chg});
      tick();
      e = exp_q.pop_front();
      chk($sformatf("t1_row%0d", r), 16'({out, rise, fall, changed}), 16'(e));
    end
  endtask

  initial begin
    logic h[10];
    logic prev, eb;
    int   nrise;

    // 1: reset and latency (3 reset edges, then out flips on 7th release edge)
    for (int r = 0; r < 12; r++) begin
      tbl[r] = '{rst_n: (r >= 3), din: 4'hF, len: 4'd5, mode: 1'b0,
                 e_out: 4'h0, e_rise: 4'h0, e_fall: 4'h0, e_chg: 1'b0};
      if (r >= 9) tbl[r].e_out = 4'hF;
    end
    tbl[9].e_rise = 4'hF;
    tbl[9].e_chg  = 1'b1;
    run_table();

    // 2: glitch rejection in consecutive mode
    filt_len = 4'd5;
    do_reset(1'b0);
    for (int e = 1; e <= 14; e++) begin
      din = {3'b000, pat[e-1][0]};
      tick();
      chk($sformatf("t2_out_e%0d", e), 16'(out[0]), 16'd0);
      chk($sformatf("t2_rise_e%0d", e), 16'(rise[0]), 16'd0);
      case (e)
        6:  chk_cnt("t2_cnt_e6", 0, 16'd4);
        7:  chk_cnt("t2_cnt_e7", 0, 16'd0);
        11: chk_cnt("t2_cnt_e11", 0, 16'd4);
        12: chk_cnt("t2_cnt_e12", 0, 16'd0);
        default: ;
      endcase
    end

    // 3: integrating mode tolerates the single low sample
    do_reset(1'b1);
    nrise = 0;
    for (int e = 1; e <= 11; e++) begin
      din = {3'b000, pat[e-1][0]};
      tick();
      if (rise[0]) nrise++;
      chk($sformatf("t3_out_e%0d", e), 16'(out[0]), (e >= 9) ? 16'd1 : 16'd0);
      case (e)
        6:  chk_cnt("t3_cnt_e6", 0, 16'd4);
        7:  chk_cnt("t3_cnt_e7", 0, 16'd3);
        8:  chk_cnt("t3_cnt_e8", 0, 16'd4);
        9:  chk("t3_chg_e9", 16'({rise, changed}), 16'h03);
        10: chk_cnt("t3_cnt_e10", 0, 16'd0);
        default: ;
      endcase
    end
    chk("t3_rise_count", 16'(nrise), 16'd1);

    // 4: filt_len=0 acts as 1; out tracks in with 3 edges of delay
    filt_len = 4'd0;
    do_reset(1'b0);
    prev = 1'b0;
    for (int j = 0; j < 10; j++) begin
      h[j] = (j % 2 == 0);
      din  = {2'b00, h[j], 1'b0};
      tick();
      eb = 1'b0;
      if (j >= 2) eb = h[j-2];
      chk($sformatf("t4_out_%0d", j), 16'(out[1]), 16'(eb));
      chk($sformatf("t4_rise_%0d", j), 16'(rise[1]), 16'(eb & ~prev));
      chk($sformatf("t4_fall_%0d", j), 16'(fall[1]), 16'(~eb & prev));
      chk($sformatf("t4_both_%0d", j), 16'(rise & fall), 16'd0);
      chk($sformatf("t4_other_%0d", j), 16'(out & 4'b1101), 16'd0);
      prev = eb;
    end

    // 5: lowering the threshold mid-count flips on the next edge
    filt_len = 4'd10;
    do_reset(1'b0);
    din = 4'h4;
    for (int e = 1; e <= 8; e++) tick();
    chk_cnt("t5_cnt", 2, 16'd6);
    chk("t5_out_pre", 16'(out), 16'h0);
    filt_len = 4'd3;
    tick();
    chk("t5_out", 16'(out), 16'h4);
    chk("t5_rise", 16'({rise, fall}), 16'h40);
    tick();
    chk("t5_rise_end", 16'({out, rise}), 16'h40);

    // 6a: reset mid-count discards progress
    filt_len = 4'd5;
    do_reset(1'b0);
    din = 4'h8;
    for (int e = 1; e <= 5; e++) tick();
    chk_cnt("t6a_cnt_pre", 3, 16'd3);
    rst_n = 1'b0;
    tick();
    chk("t6a_rst", 16'({out, rise, fall, changed}), 16'h0);
    chk_cnt("t6a_cnt_rst", 3, 16'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    chk("t6a_out_e6", 16'(out), 16'h0);
    chk_cnt("t6a_cnt_e6", 3, 16'd4);
    tick();
    chk("t6a_out_e7", 16'({out, rise}), 16'h88);

    // 6b: mode toggle mid-count clears counters without flipping
    do_reset(1'b0);
    din = 4'h8;
    for (int e = 1; e <= 5; e++) tick();
    chk_cnt("t6b_cnt_pre", 3, 16'd3);
    mode = 1'b1;
    tick();
    chk_cnt("t6b_cnt_chg", 3, 16'd0);
    chk("t6b_chg", 16'({out, rise, fall, changed}), 16'h0);
    for (int e = 1; e <= 4; e++) tick();
    chk_cnt("t6b_cnt_e4", 3, 16'd4);
    chk("t6b_out_e4", 16'(out), 16'h0);
    tick();
    chk("t6b_out_e5", 16'({out, rise}), 16'h88);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
